micro_sequencer: RTL and testbench



---
 rtl/micro_sequencer.sv | 131 +++++++++++++
 tb/tb_micro_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Next-state stage of the microprogrammed control unit: registers the control-state
// number feeding the microstore. Optional hold timeout trap: MICRO_SEQUENCER_WAIT_TIMEOUT_EN.
module micro_sequencer #(
    parameter int STATE_W       = 7,
    parameter int RESET_STATE   = 0,
    parameter int FETCH_STATE   = 1,
    parameter int ILLEGAL_STATE = 5,
    parameter int WAIT_TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instruction,
    input  logic [2:0]         nextSel,
    input  logic [1:0]         condSel,
    input  logic               invert,
    input  logic [STATE_W-1:0] crAddr,
    input  logic               moc,
    input  logic               zero,
    input  logic               negative,
    output logic [STATE_W-1:0] currentState,
`ifdef MICRO_SEQUENCER_WAIT_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic               waiting,
    output logic [15:0]        instrCount
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               cond;
    logic [STATE_W-1:0] inc;
    logic [STATE_W-1:0] enc;
    logic [STATE_W-1:0] sel_next;
    logic               unused_ok;

    assign unused_ok = ^instruction[25:0];

    always_comb begin
        cond = 1'b1;
        case (condSel)
            2'b00:   cond = moc;
            2'b01:   cond = zero;
            2'b10:   cond = negative;
            default: cond = 1'b1;
        endcase
        cond = cond ^ invert;
    end

    assign inc     = state_q + STATE_W'(1);
    assign waiting = (nextSel == 3'b100) && !cond;

    always_comb begin
        enc = STATE_W'(ILLEGAL_STATE);
        case (instruction[31:26])
            6'h00:   enc = STATE_W'(6);
            6'h23:   enc = STATE_W'(7);
            6'h2B:   enc = STATE_W'(13);
            6'h04:   enc = STATE_W'(11);
            6'h02:   enc = STATE_W'(12);
            6'h08:   enc = STATE_W'(17);
            6'h0C:   enc = STATE_W'(19);
            6'h0D:   enc = STATE_W'(21);
            default: enc = STATE_W'(ILLEGAL_STATE);
        endcase
    end

    always_comb begin
        sel_next = STATE_W'(RESET_STATE);
        case (nextSel)
            3'b000:  sel_next = enc;
            3'b001:  sel_next = STATE_W'(FETCH_STATE);
            3'b010:  sel_next = crAddr;
            3'b011:  sel_next = inc;
            3'b100:  sel_next = cond ? crAddr : state_q;
            3'b101:  sel_next = cond ? crAddr : inc;
            3'b110:  sel_next = cond ? crAddr : enc;
            default: sel_next = STATE_W'(RESET_STATE);
        endcase
    end

`ifdef MICRO_SEQUENCER_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             trap;
    logic             timeout_q;

    // A hold that has already lasted WAIT_TIMEOUT-1 edges becomes a trap on this edge.
    assign trap = waiting && (hold_q == CNT_W'(WAIT_TIMEOUT - 1));

    always_comb begin
        hold_d  = '0;
        state_d = sel_next;
        if (trap) begin
            state_d = STATE_W'(ILLEGAL_STATE);
        end else if (waiting) begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= trap;
        end
    end

    assign timeout = timeout_q;
`else
    assign state_d = sel_next;
`endif

    assign cnt_d = (state_d == STATE_W'(FETCH_STATE)) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_W'(RESET_STATE);
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign currentState = state_q;
    assign instrCount   = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer (default build): directed plan steps, then random microwords.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [2:0]  nextSel;
    logic [1:0]  condSel;
    logic        invert;
    logic [6:0]  crAddr;
    logic        moc, zero, negative;
    logic [6:0]  currentState;
    logic        waiting;
    logic [15:0] instrCount;

    micro_sequencer dut (
        .clk(clk), .reset(reset), .instruction(instruction), .nextSel(nextSel),
        .condSel(condSel), .invert(invert), .crAddr(crAddr), .moc(moc),
        .zero(zero), .negative(negative), .currentState(currentState),
        .waiting(waiting), .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          st;
        int          cnt;
        bit          wt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   drv_done = 0;

    // reference model state
    int   m_state = 0;
    int   m_cnt = 0;
    int   enc_tab[int];

    function automatic int encode(int op);
        if (enc_tab.exists(op)) return enc_tab[op];
        return 5;
    endfunction

    task automatic step(input bit rst, input int ns, input int cs, input bit inv,
                        input int cr, input logic [31:0] ins,
                        input bit m, input bit z, input bit n);
        exp_t e;
        bit   src, c;
        int   nxt;
        @(negedge clk);
        reset = rst; nextSel = 3'(ns); condSel = 2'(cs); invert = inv;
        crAddr = 7'(cr); instruction = ins; moc = m; zero = z; negative = n;
        src = (cs == 0) ? m : (cs == 1) ? z : (cs == 2) ? n : 1'b1;
        c   = src != inv;
        case (ns)
            0: nxt = encode(int'(ins >> 26));
            1: nxt = 1;
            2: nxt = cr;
            3: nxt = (m_state + 1) % 128;
            4: nxt = c ? cr : m_state;
            5: nxt = c ? cr : (m_state + 1) % 128;
            6: nxt = c ? cr : encode(int'(ins >> 26));
            default: nxt = 0;
        endcase
        e.wt = (ns == 4) && !c;
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
        end else begin
            if (nxt == 1) m_cnt = (m_cnt + 1) % 65536;
            m_state = nxt;
        end
        e.st  = m_state;
        e.cnt = m_cnt;
        q.push_back(e);
    endtask

    // monitor: waiting sampled mid-low phase, registered outputs just after the edge
    initial begin : monitor
        exp_t e;
        bit   w_s;
        forever begin
            @(negedge clk);
            #2 w_s = waiting;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (w_s !== e.wt) begin
                    fails++;
                    $display("FAIL waiting got=%0b want=%0b t=%0t", w_s, e.wt, $time);
                end
                tests++;
                if (currentState !== 7'(e.st)) begin
                    fails++;
                    $display("FAIL currentState got=%0d want=%0d t=%0t", currentState, e.st, $time);
                end
                tests++;
                if (instrCount !== 16'(e.cnt)) begin
                    fails++;
                    $display("FAIL instrCount got=%0d want=%0d t=%0t", instrCount, e.cnt, $time);
                end
            end
        end
    end

    initial begin : driver
        int ops[9];
        ops = '{32'h00, 32'h23, 32'h2B, 32'h04, 32'h02, 32'h08, 32'h0C, 32'h0D, 32'h3F};
        enc_tab[32'h00] = 6;  enc_tab[32'h23] = 7;  enc_tab[32'h2B] = 13;
        enc_tab[32'h04] = 11; enc_tab[32'h02] = 12; enc_tab[32'h08] = 17;
        enc_tab[32'h0C] = 19; enc_tab[32'h0D] = 21;
        reset = 1; nextSel = 3; condSel = 0; invert = 0; crAddr = 0;
        instruction = 0; moc = 0; zero = 0; negative = 0;

        // reset then fetch
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // decode lw and an unsupported opcode
        step(0, 2, 0, 0, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h8C820004, 0, 0, 0);
        step(0, 2, 0, 0, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'hFC000000, 0, 0, 0);
        // memory wait, three held cycles then release
        for (int i = 0; i < 3; i++) step(0, 4, 0, 0, 4, 0, 0, 0, 0);
        step(0, 4, 0, 0, 4, 0, 1, 0, 0);
        // inverted zero branch: taken only when zero=0
        step(0, 5, 1, 1, 12, 0, 0, 1, 0);
        step(0, 5, 1, 1, 12, 0, 0, 0, 0);
        // 127 wraps to 0
        step(0, 2, 0, 0, 127, 0, 0, 0, 0);
        step(0, 3, 0, 0, 0, 0, 0, 0, 0);
        // reset asserted while holding
        step(0, 2, 0, 0, 9, 0, 0, 0, 0);
        step(0, 4, 0, 0, 4, 0, 0, 0, 0);
        step(1, 4, 0, 0, 4, 0, 0, 0, 0);
        step(0, 4, 0, 0, 4, 0, 0, 0, 0);
        // fetch while already in fetch still counts
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = ($urandom_range(0, 3) == 0) ? $urandom()
                  : ((32'(ops[$urandom_range(0, 8)]) << 26) | ($urandom() & 32'h03FF_FFFF));
            step($urandom_range(0, 63) == 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), 1'($urandom()),
                 int'($urandom_range(0, 127)), ins,
                 1'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        drv_done = 1;
    end

    initial begin : finisher
        int guard;
        guard = 0;
        while (!drv_done && guard < 50000) begin
            @(posedge clk);
            guard++;
        end
        tests++;
        if (!drv_done) begin
            fails++;
            $display("FAIL driver_timeout cycles=%0d limit=%0d", guard, 50000);
        end
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
